key_out_fifo: RTL
=================

// Module: key_out_fifo
// PURPOSE
//  Downstream stage of the keypoint buffer. Captures each keypoint popped from the buffer head on i_hit and
//  queues it for the descriptor/matcher stage behind a valid/ready handshake. Inserts an end-of-frame marker
//  on i_frame_end, counts keypoints per frame and flags overflow. Empty slots (score 0) are discarded.
// PARAMETERS
//  DEPTH  64  FIFO entries; power of two, >= 4
//  AW     6   pointer width, log2(DEPTH)
// PORTS
//  i_clk         in   1   clock, rising edge
//  i_rst         in   1   synchronous reset, active-high
//  i_hit         in   1   buffer head is presented this cycle
//  i_sin         in   12  keypoint orientation sine
//  i_cos         in   12  keypoint orientation cosine
//  i_coor_x      in   10  keypoint x
//  i_coor_y      in   10  keypoint y
//  i_score       in   8   keypoint score; 0 = empty slot
//  i_frame_end   in   1   one-cycle pulse after the last pixel of a frame
//  i_ready       in   1   consumer accepts the output entry
//  o_valid       out  1   output entry valid
//  o_sin/o_cos   out  12  entry orientation
//  o_coor_x/y    out  10  entry coordinates
//  o_score       out  8   entry score
//  o_last        out  1   entry closes a frame
//  o_frame_keys  out  10  keypoints accepted in the previous frame
//  o_full        out  1   count == DEPTH
//  o_empty       out  1   count == 0
//  o_drop        out  1   sticky: an entry was discarded for lack of space
// BEHAVIOUR
//  - Entry = {last, sin, cos, x, y, score}, 53 bits. Register array; read pointer, write pointer, count (AW+1 bits).
//  - Output is first-word-fallthrough: o_* = mem[rd_ptr]; o_valid = (count != 0). Pop when o_valid && i_ready.
//  - Key accept: i_hit && i_score != 0 && count < DEPTH-1. The last slot is reserved for the frame marker.
//    A key arriving while count >= DEPTH-1 is discarded and sets o_drop.
//  - i_frame_end without accepted key: push marker {last=1, all payload 0} if count < DEPTH; else discard, set o_drop.
//  - i_frame_end with accepted key in the same cycle: push one entry carrying the key with last=1 (no marker).
//  - Space checks use the registered count. A pop in the same cycle frees no space for a push in that cycle.
//  - Simultaneous push and pop: count unchanged, both pointers advance; order preserved.
//  - Pointers wrap modulo DEPTH. Latency: a push at edge N is visible at o_* with o_valid=1 after edge N (0-cycle fallthrough).
//  - frame_cnt: increments per accepted key, saturates at 1023.
//    On i_frame_end: o_frame_keys <= frame_cnt + (coincident accept ? 1 : 0), saturated; frame_cnt <= 0.
//  - o_drop stays set until reset.
//  - Reset (any time, including mid-frame): pointers, count, frame_cnt and o_frame_keys go to 0; o_drop goes to 0.
//    So o_valid=0, o_empty=1, o_full=0. Memory contents are not reset; o_* payload is don't-care while o_valid=0.
// TESTING
//  1 Assert i_rst 2 cycles -> o_valid=0, o_empty=1, o_full=0, o_drop=0, o_frame_keys=0.
//  2 Hits at (10,20,s5),(11,20,s0),(12,20,s9), i_ready=1 -> outputs (10,20,5) then (12,20,9), o_last=0, no third entry.
//  3 After test 2, pulse i_frame_end -> one entry x=y=score=0 with o_last=1; o_frame_keys=2.
//  4 DEPTH=4, i_ready=0: 5 hits with score 1..5 -> scores 1,2,3 kept, o_drop=1, o_full=0.
//    Then i_frame_end -> marker queued, o_full=1.
//  5 i_hit (score 7) together with i_frame_end after 3 keys -> single entry score 7, o_last=1; o_frame_keys=4.
//  6 count=2, push+pop in the same cycle -> count stays 2, FIFO order intact; then i_rst mid-stream -> o_empty=1 next cycle.

Source files
------------

// File: rtl/key_out_fifo.sv
// key_out_fifo: output queue between the keypoint buffer and the descriptor stage.
// Accepts non-empty keypoints popped from the buffer head and tags frame boundaries.
// It counts the keypoints in each frame and keeps a sticky flag when an entry is lost.
// The read side is first-word-fallthrough behind a valid/ready handshake.
module key_out_fifo #(
   parameter int DEPTH = 64,
   parameter int AW    = 6
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_hit,
   input  logic [11:0] i_sin,
   input  logic [11:0] i_cos,
   input  logic [9:0]  i_coor_x,
   input  logic [9:0]  i_coor_y,
   input  logic [7:0]  i_score,
   input  logic        i_frame_end,
   input  logic        i_ready,
   output logic        o_valid,
   output logic [11:0] o_sin,
   output logic [11:0] o_cos,
   output logic [9:0]  o_coor_x,
   output logic [9:0]  o_coor_y,
   output logic [7:0]  o_score,
   output logic        o_last,
   output logic [9:0]  o_frame_keys,
   output logic        o_full,
   output logic        o_empty,
   output logic        o_drop
);

   localparam int          EW         = 53;
   localparam logic [AW:0] L_DEPTH    = (AW+1)'(DEPTH);
   localparam logic [AW:0] L_DEPTH_M1 = (AW+1)'(DEPTH - 1);
   localparam logic [AW:0] L_ONE      = (AW+1)'(1);
   localparam logic [9:0]  L_KEYS_MAX = 10'd1023;

   logic [EW-1:0] r_mem [DEPTH];
   logic [AW-1:0] r_rd_ptr;
   logic [AW-1:0] r_wr_ptr;
   logic [AW:0]   r_count;
   logic [9:0]    r_frame_cnt;
   logic [9:0]    r_frame_keys;
   logic          r_drop;

   logic          w_key_ok;
   logic          w_key_acc;
   logic          w_key_drop;
   logic          w_mark_acc;
   logic          w_mark_drop;
   logic          w_push;
   logic          w_pop;
   logic [EW-1:0] w_wr_data;
   logic [EW-1:0] w_head;
   logic [10:0]   w_keys_sum;

   // A key only goes in while the last slot is still free, so the frame marker
   // always has room. All space checks use the registered count, which means
   // a same-cycle pop never makes room for a push.
   assign w_key_ok    = i_hit && (i_score != 8'd0);
   assign w_key_acc   = w_key_ok && (r_count < L_DEPTH_M1);
   assign w_key_drop  = w_key_ok && !(r_count < L_DEPTH_M1);
   assign w_mark_acc  = i_frame_end && !w_key_acc && (r_count < L_DEPTH);
   assign w_mark_drop = i_frame_end && !w_key_acc && !(r_count < L_DEPTH);
   assign w_push      = w_key_acc || w_mark_acc;
   assign w_pop       = (r_count != '0) && i_ready;

   // When a key arrives on the frame-end cycle, the key carries last=1 and no separate marker is written.
   assign w_wr_data   = w_key_acc ? {i_frame_end, i_sin, i_cos, i_coor_x, i_coor_y, i_score}
                                  : {1'b1, 52'd0};

   assign w_keys_sum  = {1'b0, r_frame_cnt} + {10'd0, w_key_acc};

   assign w_head       = r_mem[r_rd_ptr];
   assign o_last       = w_head[52];
   assign o_sin        = w_head[51:40];
   assign o_cos        = w_head[39:28];
   assign o_coor_x     = w_head[27:18];
   assign o_coor_y     = w_head[17:8];
   assign o_score      = w_head[7:0];
   assign o_valid      = (r_count != '0);
   assign o_empty      = (r_count == '0);
   assign o_full       = (r_count == L_DEPTH);
   assign o_frame_keys = r_frame_keys;
   assign o_drop       = r_drop;

   // Entry storage; contents survive reset because the pointers define validity.
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= w_wr_data;
      end
   end

   // Pointers and occupancy; pointers wrap naturally at DEPTH.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + L_ONE;
            2'b01:   r_count <= r_count - L_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   // Per-frame keypoint count, latched into o_frame_keys at frame end (saturating).
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_frame_cnt  <= '0;
         r_frame_keys <= '0;
      end else if (i_frame_end) begin
         r_frame_cnt  <= '0;
         r_frame_keys <= w_keys_sum[10] ? L_KEYS_MAX : w_keys_sum[9:0];
      end else if (w_key_acc && (r_frame_cnt != L_KEYS_MAX)) begin
         r_frame_cnt  <= r_frame_cnt + 10'd1;
      end
   end

   // Sticky loss flag for any key or marker that found no room.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_drop <= 1'b0;
      end else if (w_key_drop || w_mark_drop) begin
         r_drop <= 1'b1;
      end
   end

endmodule
